// File: rtl/run_sequencer_if.sv
// Host/core bundle for the run sequencer: start handshake, program table,
// branch controls from the core, and the sequencer's status outputs.
interface run_sequencer_if #(
  parameter int T = 10,
  parameter int P = 4,
  parameter int C = 16
);
  logic                 req;
  logic [$clog2(P)-1:0] prog_sel;
  logic [P*T-1:0]       start_addr;
  logic                 BranchAlways;
  logic                 BranchEZ;
  logic                 BranchNZ;
  logic                 Zero;
  logic [T-1:0]         Target;
  logic                 Done;
  logic [C-1:0]         cycle_limit;
  logic [T-1:0]         ProgCtr;
  logic [T-1:0]         ProgCtr_p1;
  logic                 run;
  logic                 ack;
  logic                 timeout;
  logic [C-1:0]         cycles;

  // Host and core side: drives requests and branch controls, reads status.
  modport master (
    output req, prog_sel, start_addr, BranchAlways, BranchEZ, BranchNZ,
           Zero, Target, Done, cycle_limit,
    input  ProgCtr, ProgCtr_p1, run, ack, timeout, cycles
  );

  // Sequencer side.
  modport slave (
    input  req, prog_sel, start_addr, BranchAlways, BranchEZ, BranchNZ,
           Zero, Target, Done, cycle_limit,
    output ProgCtr, ProgCtr_p1, run, ack, timeout, cycles
  );
endinterface

// File: rtl/run_sequencer.sv
// Run sequencer: IDLE -> LOAD -> RUN -> FINISH program-counter controller
// with branch handling, a saturating cycle counter and an optional watchdog.
module run_sequencer #(
  parameter int T = 10,
  parameter int P = 4,
  parameter int C = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  run_sequencer_if.slave bus
);
  localparam int SW = $clog2(P);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [SW-1:0]  sel_reg, sel_next;
  logic [T-1:0]   pc_reg, pc_next;
  logic [C-1:0]   cyc_reg, cyc_next;
  logic           tmo_reg, tmo_next;
  logic           run_reg, ack_reg;

  logic [T-1:0]   entry [P];
  logic [T-1:0]   pc_p1;
  logic [C:0]     cyc_plus;
  logic           taken;
  logic           watchdog_hit;

  // Unpack the flat entry-point table into one address per program.
  for (genvar gi = 0; gi < P; gi++) begin : g_entry
    assign entry[gi] = bus.start_addr[gi*T +: T];
  end

  assign pc_p1    = pc_reg + T'(1);
  // One extra bit so a saturated counter never aliases onto a small limit.
  assign cyc_plus = {1'b0, cyc_reg} + {{C{1'b0}}, 1'b1};
  // All three branch conditions share the same destination, so their
  // priority order collapses to a single OR.
  assign taken    = bus.BranchAlways
                  | (bus.BranchEZ & bus.Zero)
                  | (bus.BranchNZ & ~bus.Zero);
  assign watchdog_hit = (bus.cycle_limit != '0) &&
                        (cyc_plus == {1'b0, bus.cycle_limit});

  // Next-state and datapath decisions for each sequencer state.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    pc_next    = pc_reg;
    cyc_next   = cyc_reg;
    tmo_next   = tmo_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          state_next = LOAD;
          // An out-of-range program index falls back to program 0.
          sel_next   = (int'(bus.prog_sel) < P) ? bus.prog_sel : '0;
        end
      end
      LOAD: begin
        pc_next    = entry[sel_reg];
        cyc_next   = '0;
        tmo_next   = 1'b0;
        state_next = RUN;
      end
      RUN: begin
        if (bus.Done) begin
          // The completion edge is not an executed step: PC and the cycle
          // count stay exactly as they were when the core signalled Done.
          state_next = FINISH;
          tmo_next   = 1'b0;
        end else begin
          pc_next  = taken ? bus.Target : pc_p1;
          cyc_next = cyc_plus[C] ? cyc_reg : cyc_plus[C-1:0];
          if (watchdog_hit) begin
            state_next = FINISH;
            tmo_next   = 1'b1;
          end
        end
      end
      FINISH: begin
        if (!bus.req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; run/ack are decoded from the next state so
  // they are registered and line up with the state they describe.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      pc_reg    <= '0;
      cyc_reg   <= '0;
      tmo_reg   <= 1'b0;
      run_reg   <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      pc_reg    <= pc_next;
      cyc_reg   <= cyc_next;
      tmo_reg   <= tmo_next;
      run_reg   <= (state_next == RUN);
      ack_reg   <= (state_next == FINISH);
    end
  end

  assign bus.ProgCtr    = pc_reg;
  assign bus.ProgCtr_p1 = pc_p1;
  assign bus.run        = run_reg;
  assign bus.ack        = ack_reg;
  assign bus.timeout    = tmo_reg;
  assign bus.cycles     = cyc_reg;
endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: scenario tasks with a scoreboard of
// expected end-of-run results compared when ack rises.
module tb_run_sequencer;
  localparam int T = 10;
  localparam int P = 4;
  localparam int C = 16;

  typedef struct packed {
    logic [T-1:0] pc;
    logic [C-1:0] cyc;
    logic         tmo;
  } res_t;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   passed = 0;
  res_t exp_q[$];

  always #5 Clk = ~Clk;

  run_sequencer_if #(.T(T), .P(P), .C(C)) bus ();

  run_sequencer #(.T(T), .P(P), .C(C)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic wait_ack(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bus.ack === 1'b1) seen = 1'b1;
      else step();
    end
    if (bus.ack === 1'b1) seen = 1'b1;
  endtask

  task automatic clear_ctrl();
    bus.BranchAlways = 1'b0;
    bus.BranchEZ     = 1'b0;
    bus.BranchNZ     = 1'b0;
    bus.Zero         = 1'b0;
    bus.Target       = '0;
    bus.Done         = 1'b0;
  endtask

  // IDLE -> LOAD -> RUN; returns with the sequencer in its first RUN cycle.
  task automatic start_run(input int sel);
    bus.prog_sel = sel[$clog2(P)-1:0];
    bus.req      = 1'b1;
    step_n(2);
  endtask

  task automatic test_reset();
    checks++; if (bus.ProgCtr !== 10'h000) $display("FAIL reset_pc: got %h expected 000", bus.ProgCtr); else passed++;
    checks++; if (bus.cycles !== 16'd0) $display("FAIL reset_cycles: got %0d expected 0", bus.cycles); else passed++;
    checks++; if ({bus.run, bus.ack, bus.timeout} !== 3'b000) $display("FAIL reset_flags: got run/ack/timeout=%b expected 000", {bus.run, bus.ack, bus.timeout}); else passed++;
    checks++; if (bus.ProgCtr_p1 !== 10'h001) $display("FAIL reset_p1: got %h expected 001", bus.ProgCtr_p1); else passed++;
    step();
    Reset = 1'b1;
    step_n(3);
    checks++; if ({bus.run, bus.ack} !== 2'b00) $display("FAIL reset_stay_idle: got run/ack=%b expected 00", {bus.run, bus.ack}); else passed++;
  endtask

  task automatic test_normal();
    bit   seen;
    res_t got;
    res_t e;
    start_run(1);
    checks++; if (bus.ProgCtr !== 10'h040) $display("FAIL normal_load_pc: got %h expected 040", bus.ProgCtr); else passed++;
    checks++; if (bus.ProgCtr_p1 !== 10'h041) $display("FAIL normal_p1: got %h expected 041", bus.ProgCtr_p1); else passed++;
    checks++; if (bus.run !== 1'b1) $display("FAIL normal_run: got %b expected 1", bus.run); else passed++;
    step_n(5);
    exp_q.push_back('{pc: 10'h045, cyc: 16'd5, tmo: 1'b0});
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    wait_ack(4, seen);
    checks++; if (!seen) $display("FAIL normal_ack: got ack=%b expected 1", bus.ack); else passed++;
    got = {bus.ProgCtr, bus.cycles, bus.timeout};
    e = exp_q.pop_front();
    $display("txn normal pc=%h cycles=%0d timeout=%b", got.pc, got.cyc, got.tmo);
    checks++; if (got !== e) $display("FAIL normal_result: got pc=%h cyc=%0d tmo=%b expected pc=%h cyc=%0d tmo=%b", got.pc, got.cyc, got.tmo, e.pc, e.cyc, e.tmo); else passed++;
    checks++; if (bus.run !== 1'b0) $display("FAIL normal_finish_run: got %b expected 0", bus.run); else passed++;
    step_n(2);
    checks++; if ({bus.ack, bus.ProgCtr, bus.cycles} !== {1'b1, 10'h045, 16'd5}) $display("FAIL normal_frozen: got ack=%b pc=%h cyc=%0d expected 1 045 5", bus.ack, bus.ProgCtr, bus.cycles); else passed++;
    bus.req = 1'b0;
    step();
    checks++; if (bus.ack !== 1'b0) $display("FAIL normal_ack_fall: got %b expected 0", bus.ack); else passed++;
    step();
    checks++; if ({bus.ProgCtr, bus.cycles} !== {10'h045, 16'd5}) $display("FAIL normal_idle_hold: got pc=%h cyc=%0d expected 045 5", bus.ProgCtr, bus.cycles); else passed++;
  endtask

  task automatic test_branch();
    bit   seen;
    res_t got;
    res_t e;
    start_run(2);
    bus.BranchAlways = 1'b1; bus.BranchEZ = 1'b1; bus.Zero = 1'b1; bus.Target = 10'h100;
    step();
    checks++; if (bus.ProgCtr !== 10'h100) $display("FAIL branch_always: got %h expected 100", bus.ProgCtr); else passed++;
    bus.BranchAlways = 1'b0; bus.BranchEZ = 1'b0; bus.BranchNZ = 1'b1; bus.Zero = 1'b1; bus.Target = 10'h2AA;
    step();
    checks++; if (bus.ProgCtr !== 10'h101) $display("FAIL branch_nz_not_taken: got %h expected 101", bus.ProgCtr); else passed++;
    bus.BranchNZ = 1'b0; bus.BranchEZ = 1'b1; bus.Zero = 1'b1; bus.Target = 10'h200;
    step();
    checks++; if (bus.ProgCtr !== 10'h200) $display("FAIL branch_ez_taken: got %h expected 200", bus.ProgCtr); else passed++;
    bus.BranchEZ = 1'b0; bus.BranchNZ = 1'b1; bus.Zero = 1'b0; bus.Target = 10'h300;
    step();
    checks++; if (bus.ProgCtr !== 10'h300) $display("FAIL branch_nz_taken: got %h expected 300", bus.ProgCtr); else passed++;
    clear_ctrl();
    exp_q.push_back('{pc: 10'h300, cyc: 16'd4, tmo: 1'b0});
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    bus.BranchAlways = 1'b1; bus.Target = 10'h155;
    wait_ack(4, seen);
    checks++; if (!seen) $display("FAIL branch_ack: got ack=%b expected 1", bus.ack); else passed++;
    got = {bus.ProgCtr, bus.cycles, bus.timeout};
    e = exp_q.pop_front();
    $display("txn branch pc=%h cycles=%0d timeout=%b", got.pc, got.cyc, got.tmo);
    checks++; if (got !== e) $display("FAIL branch_result: got pc=%h cyc=%0d tmo=%b expected pc=%h cyc=%0d tmo=%b", got.pc, got.cyc, got.tmo, e.pc, e.cyc, e.tmo); else passed++;
    step();
    checks++; if (bus.ProgCtr !== 10'h300) $display("FAIL branch_ignored_in_finish: got %h expected 300", bus.ProgCtr); else passed++;
    clear_ctrl();
    bus.req = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    bit   seen;
    res_t got;
    res_t e;
    start_run(3);
    checks++; if ({bus.ProgCtr, bus.ProgCtr_p1} !== {10'h3FE, 10'h3FF}) $display("FAIL wrap_start: got pc=%h p1=%h expected 3fe 3ff", bus.ProgCtr, bus.ProgCtr_p1); else passed++;
    step();
    checks++; if ({bus.ProgCtr, bus.ProgCtr_p1} !== {10'h3FF, 10'h000}) $display("FAIL wrap_top: got pc=%h p1=%h expected 3ff 000", bus.ProgCtr, bus.ProgCtr_p1); else passed++;
    step();
    checks++; if (bus.ProgCtr !== 10'h000) $display("FAIL wrap_zero: got %h expected 000", bus.ProgCtr); else passed++;
    exp_q.push_back('{pc: 10'h000, cyc: 16'd2, tmo: 1'b0});
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    wait_ack(4, seen);
    checks++; if (!seen) $display("FAIL wrap_ack: got ack=%b expected 1", bus.ack); else passed++;
    got = {bus.ProgCtr, bus.cycles, bus.timeout};
    e = exp_q.pop_front();
    $display("txn wrap pc=%h cycles=%0d timeout=%b", got.pc, got.cyc, got.tmo);
    checks++; if (got !== e) $display("FAIL wrap_result: got pc=%h cyc=%0d tmo=%b expected pc=%h cyc=%0d tmo=%b", got.pc, got.cyc, got.tmo, e.pc, e.cyc, e.tmo); else passed++;
    bus.req = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    bit   seen;
    int   runs;
    res_t got;
    res_t e;
    bus.cycle_limit = 16'd8;
    exp_q.push_back('{pc: 10'h008, cyc: 16'd8, tmo: 1'b1});
    start_run(0);
    seen = 1'b0;
    runs = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.ack === 1'b1) seen = 1'b1;
      else begin
        if (bus.run === 1'b1) runs++;
        step();
      end
    end
    checks++; if (!seen) $display("FAIL wd_ack: got ack=%b expected 1", bus.ack); else passed++;
    checks++; if (runs != 8) $display("FAIL wd_run_edges: got %0d expected 8", runs); else passed++;
    got = {bus.ProgCtr, bus.cycles, bus.timeout};
    e = exp_q.pop_front();
    $display("txn watchdog pc=%h cycles=%0d timeout=%b", got.pc, got.cyc, got.tmo);
    checks++; if (got !== e) $display("FAIL wd_result: got pc=%h cyc=%0d tmo=%b expected pc=%h cyc=%0d tmo=%b", got.pc, got.cyc, got.tmo, e.pc, e.cyc, e.tmo); else passed++;
    bus.req = 1'b0;
    step_n(2);
    checks++; if (bus.timeout !== 1'b1) $display("FAIL wd_idle_timeout: got %b expected 1", bus.timeout); else passed++;
    bus.cycle_limit = 16'd0;
    start_run(0);
    checks++; if (bus.timeout !== 1'b0) $display("FAIL wd_load_clears: got %b expected 0", bus.timeout); else passed++;
    step_n(12);
    checks++; if ({bus.run, bus.cycles} !== {1'b1, 16'd12}) $display("FAIL wd_disabled: got run=%b cyc=%0d expected 1 12", bus.run, bus.cycles); else passed++;
    exp_q.push_back('{pc: 10'h00C, cyc: 16'd12, tmo: 1'b0});
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    wait_ack(4, seen);
    checks++; if (!seen) $display("FAIL wd_disabled_ack: got ack=%b expected 1", bus.ack); else passed++;
    got = {bus.ProgCtr, bus.cycles, bus.timeout};
    e = exp_q.pop_front();
    $display("txn no_watchdog pc=%h cycles=%0d timeout=%b", got.pc, got.cyc, got.tmo);
    checks++; if (got !== e) $display("FAIL wd_disabled_result: got pc=%h cyc=%0d tmo=%b expected pc=%h cyc=%0d tmo=%b", got.pc, got.cyc, got.tmo, e.pc, e.cyc, e.tmo); else passed++;
    bus.req = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    bit   seen;
    res_t got;
    res_t e;
    bus.cycle_limit = 16'd6;
    start_run(1);
    bus.req = 1'b0;
    step_n(5);
    checks++; if ({bus.run, bus.cycles} !== {1'b1, 16'd5}) $display("FAIL sim_req_drop: got run=%b cyc=%0d expected 1 5", bus.run, bus.cycles); else passed++;
    exp_q.push_back('{pc: 10'h045, cyc: 16'd5, tmo: 1'b0});
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    wait_ack(4, seen);
    checks++; if (!seen) $display("FAIL sim_ack: got ack=%b expected 1", bus.ack); else passed++;
    got = {bus.ProgCtr, bus.cycles, bus.timeout};
    e = exp_q.pop_front();
    $display("txn simultaneous pc=%h cycles=%0d timeout=%b", got.pc, got.cyc, got.tmo);
    checks++; if (got !== e) $display("FAIL sim_result: got pc=%h cyc=%0d tmo=%b expected pc=%h cyc=%0d tmo=%b", got.pc, got.cyc, got.tmo, e.pc, e.cyc, e.tmo); else passed++;
    step();
    checks++; if (bus.ack !== 1'b0) $display("FAIL sim_ack_fall: got %b expected 0", bus.ack); else passed++;
    bus.cycle_limit = 16'd0;
  endtask

  task automatic test_reset_mid();
    bus.start_addr[1*T +: T] = 10'h120;
    start_run(1);
    step_n(3);
    checks++; if (bus.ProgCtr !== 10'h123) $display("FAIL rst_mid_pc_before: got %h expected 123", bus.ProgCtr); else passed++;
    #2;
    Reset = 1'b0;
    #1;
    checks++; if ({bus.ProgCtr, bus.run, bus.ack, bus.cycles} !== {10'h000, 1'b0, 1'b0, 16'd0}) $display("FAIL rst_mid_async: got pc=%h run=%b ack=%b cyc=%0d expected 000 0 0 0", bus.ProgCtr, bus.run, bus.ack, bus.cycles); else passed++;
    bus.req = 1'b0;
    #1;
    Reset = 1'b1;
    step_n(3);
    checks++; if ({bus.run, bus.ack} !== 2'b00) $display("FAIL rst_mid_no_restart: got run/ack=%b expected 00", {bus.run, bus.ack}); else passed++;
    start_run(0);
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    checks++; if (bus.ack !== 1'b1) $display("FAIL rst_fin_reached: got ack=%b expected 1", bus.ack); else passed++;
    #2;
    Reset = 1'b0;
    #1;
    checks++; if (bus.ack !== 1'b0) $display("FAIL rst_fin_async: got ack=%b expected 0", bus.ack); else passed++;
    bus.req = 1'b0;
    #1;
    Reset = 1'b1;
    step_n(2);
    checks++; if (bus.ack !== 1'b0) $display("FAIL rst_fin_no_pulse: got ack=%b expected 0", bus.ack); else passed++;
  endtask

  initial begin
    Reset           = 1'b0;
    bus.req         = 1'b0;
    bus.prog_sel    = '0;
    bus.start_addr  = {10'h3FE, 10'h010, 10'h040, 10'h000};
    bus.cycle_limit = '0;
    clear_ctrl();
    #12;
    test_reset();
    test_normal();
    test_branch();
    test_wrap();
    test_watchdog();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
